// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the serial adder.
// Holds the FSM state encoding and the digit-counter width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  // Counter width able to hold the value n (0..n) without wrapping.
  // Guarded so a degenerate n of 0 or 1 still yields a 1-bit counter.
  function automatic int sa_cnt_width(input int n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Bit-level adder cells used by serial_adder.
// full_adder is built from two half_adder cells plus an OR for the carry;
// serial_adder chains DIGIT_W of them into a ripple digit adder.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  // First stage: a + b.
  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s1),
    .c (c1)
  );

  // Second stage: partial sum + carry-in.
  half_adder u_ha1 (
    .a (s1),
    .b (cin),
    .s (s),
    .c (c2)
  );

  // At most one of the two stage carries can be set.
  assign cout = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: WIDTH-bit operands processed DIGIT_W bits per clock,
// least significant digit first, with a start/busy/done handshake.
//
// Optional feature macro: SUBTRACT_EN
//   defined   -> adds input 'sub'; sub=1 computes A - B as A + ~B + 1
//                (C_in ignored, C_out=1 means no borrow).
//   undefined -> add only, no 'sub' port, no B-inversion logic.
//
// Handshake: start is sampled only in IDLE or DONE; when sampled high the
// operands (and C_in / sub) are latched on that edge and busy rises. busy
// stays high for exactly N = WIDTH/DIGIT_W cycles, then done pulses for one
// cycle with S/C_out valid. S/C_out hold until the next operation completes.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
`ifdef SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C_out
);

  localparam int N     = WIDTH / DIGIT_W;
  localparam int CNT_W = sa_cnt_width(N);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

  // Reject configurations where the operand does not split into whole digits.
  generate
    if ((WIDTH < 1) || (DIGIT_W < 1) || ((WIDTH % DIGIT_W) != 0)) begin : g_bad_cfg
      $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT_W");
    end
  endgenerate

  // Registered state.
  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_out_q, c_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Values captured when a new operation is accepted.
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

`ifdef SUBTRACT_EN
  // Subtraction folds into addition: invert B once at load time and force
  // the initial carry to 1, so the RUN datapath is identical for both modes.
  assign b_load     = sub ? ~B : B;
  assign carry_load = sub ? 1'b1 : C_in;
`else
  assign b_load     = B;
  assign carry_load = C_in;
`endif

  // Ripple digit adder over the low DIGIT_W bits of the operand shift regs.
  logic [DIGIT_W:0]   chain;
  logic [DIGIT_W-1:0] sum_digit;

  assign chain[0] = carry_q;

  generate
    for (genvar gi = 0; gi < DIGIT_W; gi++) begin : g_digit
      full_adder u_fa (
        .a    (a_q[gi]),
        .b    (b_q[gi]),
        .cin  (chain[gi]),
        .s    (sum_digit[gi]),
        .cout (chain[gi+1])
      );
    end
  endgenerate

  // Accumulator after inserting the new sum digit at the MSB end. After N
  // digits the first digit has travelled down to bit 0.
  logic [WIDTH-1:0] acc_shift;
  assign acc_shift = (acc_q >> DIGIT_W) | (WIDTH'(sum_digit) << (WIDTH - DIGIT_W));

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    c_out_d = c_out_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = A;
          b_d     = b_load;
          acc_d   = '0;
          carry_d = carry_load;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        a_d     = a_q >> DIGIT_W;
        b_d     = b_q >> DIGIT_W;
        acc_d   = acc_shift;
        carry_d = chain[DIGIT_W];
        cnt_d   = cnt_q + CNT_W'(1);
        // Results are published only once the final digit is in, so S/C_out
        // never show a partially built sum.
        if (cnt_q == LAST_DIGIT) begin
          state_d = DONE;
          s_d     = acc_shift;
          c_out_d = chain[DIGIT_W];
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State registers; synchronous active-low reset wins over everything,
  // so an aborted operation never reaches DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      c_out_q <= c_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign S     = s_q;
  assign C_out = c_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: an 8-bit/1-bit-digit instance plus an
// 8-bit/4-bit-digit instance sharing clock and reset.
module tb_serial_adder;

  logic clk;
  logic rst_n;

  // 8-bit, 1 bit per cycle instance
  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       sub8;
  logic       busy8, done8;
  logic [7:0] s8;
  logic       cout8;

  // 8-bit, 4 bits per cycle instance
  logic       start4;
  logic [7:0] a4, b4;
  logic       cin4;
  logic       sub4;
  logic       busy4, done4;
  logic [7:0] s4;
  logic       cout4;

  int errors = 0;
  int checks = 0;

  logic [8:0] exp_q[$];

  serial_adder #(.WIDTH(8), .DIGIT_W(1)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .A     (a8),
    .B     (b8),
    .C_in  (cin8),
`ifdef SUBTRACT_EN
    .sub   (sub8),
`endif
    .busy  (busy8),
    .done  (done8),
    .S     (s8),
    .C_out (cout8)
  );

  serial_adder #(.WIDTH(8), .DIGIT_W(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .A     (a4),
    .B     (b4),
    .C_in  (cin4),
`ifdef SUBTRACT_EN
    .sub   (sub4),
`endif
    .busy  (busy4),
    .done  (done4),
    .S     (s4),
    .C_out (cout4)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic cin, input logic sb);
    logic [7:0] nb;
    nb = ~b;
`ifdef SUBTRACT_EN
    if (sb) return {1'b0, a} + {1'b0, nb} + 9'd1;
`else
    if (sb && (nb == 8'h00)) return 9'h000; // sb is always 0 in this build
`endif
    return {1'b0, a} + {1'b0, b} + {8'd0, cin};
  endfunction

  // ---------------- drivers ----------------
  // Called just after a posedge; returns just after the accepting edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sb);
    a8 = a; b8 = b; cin8 = cin; sub8 = sb; start8 = 1'b1;
    exp_q.push_back(model(a, b, cin, sb));
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic issue4(input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sb);
    a4 = a; b4 = b; cin4 = cin; sub4 = sb; start4 = 1'b1;
    exp_q.push_back(model(a, b, cin, sb));
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  // Bounded wait for done8; reports latency in cycles and busy-high samples.
  task automatic wait_done8(output int lat, output int busy_cyc, output bit seen);
    lat = 0; busy_cyc = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy8) busy_cyc++;
      @(posedge clk); #1;
      lat++;
      if (done8) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
    start4 = 0; a4 = 0; b4 = 0; cin4 = 0; sub4 = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy8); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done8); end
    checks++; if (s8 !== 8'h00) begin errors++; $display("FAIL reset_s got=%h exp=00", s8); end
    checks++; if (cout8 !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", cout8); end
    checks++; if ({busy4, done4, cout4, s4} !== 11'd0) begin
      errors++; $display("FAIL reset_dut4 got=%h exp=000", {busy4, done4, cout4, s4});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_add;
    int lat, bc; bit seen; logic [8:0] e;
    issue8(8'h0F, 8'h01, 1'b0, 1'b0);
    wait_done8(lat, bc, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL basic_timeout got=0 exp=1"); end
    checks++; if (lat != 8) begin errors++; $display("FAIL basic_latency got=%0d exp=8", lat); end
    checks++; if (bc != 8) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=8", bc); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL basic_result got=empty-queue exp=entry"); end
    else begin
      e = exp_q.pop_front();
      if ({cout8, s8} !== e) begin errors++; $display("FAIL basic_result got=%h exp=%h", {cout8, s8}, e); end
    end
    @(posedge clk); #1;
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL done_one_cycle got=%b exp=0", done8); end
    checks++; if (s8 !== 8'h10) begin errors++; $display("FAIL s_held got=%h exp=10", s8); end
  endtask

  task automatic test_carry_cases;
    int lat, bc; bit seen; logic [8:0] e;
    issue8(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done8(lat, bc, seen);
    checks++;
    if (!seen || exp_q.size() == 0) begin errors++; $display("FAIL carry1 got=no-done exp=done"); end
    else begin
      e = exp_q.pop_front();
      if ({cout8, s8} !== e) begin errors++; $display("FAIL carry1 got=%h exp=%h", {cout8, s8}, e); end
    end
    issue8(8'hFF, 8'hFF, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    // Mid-operation the previous result must still be on the outputs.
    checks++; if ({cout8, s8} !== 9'h100) begin errors++; $display("FAIL no_half_built got=%h exp=100", {cout8, s8}); end
    wait_done8(lat, bc, seen);
    checks++;
    if (!seen || exp_q.size() == 0) begin errors++; $display("FAIL carry2 got=no-done exp=done"); end
    else begin
      e = exp_q.pop_front();
      if ({cout8, s8} !== e) begin errors++; $display("FAIL carry2 got=%h exp=%h", {cout8, s8}, e); end
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc; bit seen; logic [8:0] e;
    issue8(8'h21, 8'h13, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    // Start while busy: must be ignored for the running op, then held into DONE.
    a8 = 8'h55; b8 = 8'h0A; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    exp_q.push_back(model(8'h55, 8'h0A, 1'b0, 1'b0));
    wait_done8(lat, bc, seen);
    checks++;
    if (!seen || exp_q.size() == 0) begin errors++; $display("FAIL ignore_start got=no-done exp=done"); end
    else begin
      e = exp_q.pop_front();
      if ({cout8, s8} !== e) begin errors++; $display("FAIL ignore_start got=%h exp=%h", {cout8, s8}, e); end
    end
    @(posedge clk); #1;
    start8 = 1'b0;
    checks++; if ({busy8, done8} !== 2'b10) begin errors++; $display("FAIL no_idle_gap got=%b exp=10", {busy8, done8}); end
    wait_done8(lat, bc, seen);
    checks++; if (lat != 8) begin errors++; $display("FAIL b2b_latency got=%0d exp=8", lat); end
    checks++;
    if (!seen || exp_q.size() == 0) begin errors++; $display("FAIL b2b_result got=no-done exp=done"); end
    else begin
      e = exp_q.pop_front();
      if ({cout8, s8} !== e) begin errors++; $display("FAIL b2b_result got=%h exp=%h", {cout8, s8}, e); end
    end
  endtask

  task automatic test_reset_abort;
    int lat, bc; bit seen; bit saw_done; logic [8:0] e;
    issue8(8'hAA, 8'h0F, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    checks++; if ({busy8, done8, cout8, s8} !== 11'd0) begin
      errors++; $display("FAIL abort_outputs got=%h exp=000", {busy8, done8, cout8, s8});
    end
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8 || busy8) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got=1 exp=0"); end
    issue8(8'h12, 8'h34, 1'b0, 1'b0);
    wait_done8(lat, bc, seen);
    checks++;
    if (!seen || exp_q.size() == 0) begin errors++; $display("FAIL after_abort got=no-done exp=done"); end
    else begin
      e = exp_q.pop_front();
      if ({cout8, s8} !== e) begin errors++; $display("FAIL after_abort got=%h exp=%h", {cout8, s8}, e); end
    end
  endtask

  task automatic test_random;
    int lat, bc; bit seen; logic [8:0] e; logic sb;
    for (int n = 0; n < 10; n++) begin
      sb = 1'b0;
`ifdef SUBTRACT_EN
      sb = 1'($urandom_range(0, 1));
`endif
      issue8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), sb);
      wait_done8(lat, bc, seen);
      checks++;
      if (!seen || exp_q.size() == 0) begin errors++; $display("FAIL random_%0d got=no-done exp=done", n); end
      else begin
        e = exp_q.pop_front();
        if ({cout8, s8} !== e) begin errors++; $display("FAIL random_%0d got=%h exp=%h", n, {cout8, s8}, e); end
      end
    end
  endtask

  task automatic test_digit4;
    logic [7:0] av [3];
    logic [7:0] bv [3];
    logic       cv [3];
    logic       sv [3];
    int lat; bit seen; logic [8:0] e;
    av[0] = 8'h9C; bv[0] = 8'h7B; cv[0] = 1'b0; sv[0] = 1'b0;
    av[1] = 8'hFF; bv[1] = 8'hFF; cv[1] = 1'b1; sv[1] = 1'b0;
    av[2] = 8'h05; bv[2] = 8'h07; cv[2] = 1'b0; sv[2] = 1'b0;
`ifdef SUBTRACT_EN
    sv[2] = 1'b1;
`endif
    for (int n = 0; n < 3; n++) begin
      issue4(av[n], bv[n], cv[n], sv[n]);
      lat = 0; seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        lat++;
        if (done4) begin seen = 1'b1; break; end
      end
      checks++; if (lat != 2) begin errors++; $display("FAIL d4_latency_%0d got=%0d exp=2", n, lat); end
      checks++;
      if (!seen || exp_q.size() == 0) begin errors++; $display("FAIL d4_result_%0d got=no-done exp=done", n); end
      else begin
        e = exp_q.pop_front();
        if ({cout4, s4} !== e) begin errors++; $display("FAIL d4_result_%0d got=%h exp=%h", n, {cout4, s4}, e); end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic_add();
    test_carry_cases();
    test_back_to_back();
    test_reset_abort();
    test_random();
    test_digit4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
